// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: per-channel synchronisers, edge/level detection,
// pending latch with enable mask, and a request/acknowledge handshake towards the CPU.
module irq_controller #(
  parameter int unsigned          CHANNELS    = 4,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0]  LEVEL_MODE  = '0,
  parameter int unsigned          IDW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irq_in,
  input  logic                mask_we,
  input  logic [CHANNELS-1:0] mask_d,
  output logic [CHANNELS-1:0] mask_q,
  output logic [CHANNELS-1:0] pending,
  output logic                int_req,
  output logic [IDW-1:0]      int_id,
  input  logic                int_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic                int_req_q, int_req_d;
  logic [IDW-1:0]      int_id_q, int_id_d;

  logic [CHANNELS-1:0] sync_s;
  logic [CHANNELS-1:0] set_vec;
  logic [CHANNELS-1:0] clr_vec;
  logic [CHANNELS-1:0] eligible;
  logic                any_eligible;
  logic [IDW-1:0]      win_id;
  logic                ack_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign ack_fire = (state_q == S_REQ) && int_ack;

  always_comb begin
    set_vec = (sync_s & LEVEL_MODE) | (sync_s & ~prev_q & ~LEVEL_MODE);
    clr_vec = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      clr_vec[i] = ack_fire && (int_id_q == IDW'(i));
    end
    // Edge channels: set beats clear so a new edge is never lost. Level channels:
    // the ack clear wins, and a still-high input re-pends on the following cycle.
    pending_d = (pending_q & ~clr_vec) | (set_vec & ~(clr_vec & LEVEL_MODE));
  end

  always_comb begin
    eligible     = pending_q & mask_q;
    any_eligible = |eligible;
    win_id       = '0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (eligible[i-1]) begin
        win_id = IDW'(i - 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    int_id_d  = int_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_eligible) begin
          int_req_d = 1'b1;
          int_id_d  = win_id;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          int_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!int_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        int_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
      if (mask_we) begin
        mask_q <= mask_d;
      end
    end
  end

  assign pending = pending_q;
  assign int_req = int_req_q;
  assign int_id  = int_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expected request ids queued with stimulus,
// popped by a monitor on each rising int_req; scenario tasks check timing inline.
module tb_irq_controller;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_d;
  logic [3:0] mask_q;
  logic [3:0] pending;
  logic       int_req;
  logic [1:0] int_id;
  logic       int_ack;

  int checks;
  int failures;
  int unsigned exp_q[$];
  logic [1:0] exp_id;
  logic req_prev;

  irq_controller #(
    .CHANNELS(4),
    .SYNC_STAGES(2),
    .LEVEL_MODE(4'b0001)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .mask_we(mask_we),
    .mask_d(mask_d),
    .mask_q(mask_q),
    .pending(pending),
    .int_req(int_req),
    .int_id(int_id),
    .int_ack(int_ack)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  // Scoreboard monitor: every new request must match the next queued id.
  initial req_prev = 1'b0;
  always @(negedge clk) begin
    if (int_req === 1'b1 && req_prev !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_req: got int_id=%0d, required no request", int_id);
      end else begin
        exp_id = 2'(exp_q.pop_front());
        if (int_id !== exp_id) begin
          failures++;
          $display("FAIL sb_int_id: got %0d, required %0d", int_id, exp_id);
        end
      end
    end
    req_prev = int_req;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_d = '0; int_ack = 1'b0;
    #5;
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000 || int_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b pend=%b id=%0d, required 0 0000 0", int_req, pending, int_id);
    end
    checks++;
    if (mask_q !== 4'b1111) begin
      failures++;
      $display("FAIL reset_mask: got %b, required 1111", mask_q);
    end
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    checks++;
    if (int_req !== 1'b0 || mask_q !== 4'b1111) begin
      failures++;
      $display("FAIL reset_release: got req=%b mask=%b, required 0 1111", int_req, mask_q);
    end
  endtask

  task automatic test_single_edge();
    exp_q.push_back(2);
    irq_in = 4'b0100;
    tick(2);
    checks++;
    if (pending !== 4'b0000) begin
      failures++; $display("FAIL single_pend_e2: got %b, required 0000", pending);
    end
    tick(1);
    checks++;
    if (pending !== 4'b0100 || int_req !== 1'b0) begin
      failures++; $display("FAIL single_pend_e3: got pend=%b req=%b, required 0100 0", pending, int_req);
    end
    tick(1);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd2) begin
      failures++; $display("FAIL single_req_e4: got req=%b id=%0d, required 1 2", int_req, int_id);
    end
    int_ack = 1'b1;
    tick(1);
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000) begin
      failures++; $display("FAIL single_ack: got req=%b pend=%b, required 0 0000", int_req, pending);
    end
    int_ack = 1'b0; irq_in = '0;
    tick(5);
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000) begin
      failures++; $display("FAIL single_no_rereq: got req=%b pend=%b, required 0 0000", int_req, pending);
    end
  endtask

  task automatic test_simultaneous();
    exp_q.push_back(1);
    exp_q.push_back(3);
    irq_in = 4'b1010;
    tick(4);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd1) begin
      failures++; $display("FAIL simul_first: got req=%b id=%0d, required 1 1", int_req, int_id);
    end
    int_ack = 1'b1;
    tick(1);
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b1000) begin
      failures++; $display("FAIL simul_ack: got req=%b pend=%b, required 0 1000", int_req, pending);
    end
    int_ack = 1'b0;
    tick(1);
    checks++;
    if (int_req !== 1'b0) begin
      failures++; $display("FAIL simul_gap: got req=%b, required 0", int_req);
    end
    tick(1);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd3) begin
      failures++; $display("FAIL simul_second: got req=%b id=%0d, required 1 3", int_req, int_id);
    end
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0; irq_in = '0;
    tick(1);
    checks++;
    if (pending !== 4'b0000 || int_req !== 1'b0) begin
      failures++; $display("FAIL simul_done: got pend=%b req=%b, required 0000 0", pending, int_req);
    end
  endtask

  task automatic test_mask();
    mask_d = 4'b1110; mask_we = 1'b1;
    tick(1);
    mask_we = 1'b0;
    checks++;
    if (mask_q !== 4'b1110) begin
      failures++; $display("FAIL mask_write: got %b, required 1110", mask_q);
    end
    irq_in = 4'b0001;
    tick(4);
    irq_in = '0;
    tick(4);
    checks++;
    if (pending !== 4'b0001 || int_req !== 1'b0) begin
      failures++; $display("FAIL mask_gated: got pend=%b req=%b, required 0001 0", pending, int_req);
    end
    exp_q.push_back(0);
    mask_d = 4'b1111; mask_we = 1'b1;
    tick(1);
    mask_we = 1'b0;
    checks++;
    if (int_req !== 1'b0 || mask_q !== 4'b1111) begin
      failures++; $display("FAIL mask_old_arb: got req=%b mask=%b, required 0 1111", int_req, mask_q);
    end
    tick(1);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd0) begin
      failures++; $display("FAIL mask_unmask_req: got req=%b id=%0d, required 1 0", int_req, int_id);
    end
    int_ack = 1'b1;
    tick(1);
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000) begin
      failures++; $display("FAIL mask_ack: got req=%b pend=%b, required 0 0000", int_req, pending);
    end
    int_ack = 1'b0;
    tick(1);
  endtask

  task automatic test_level();
    exp_q.push_back(0);
    irq_in = 4'b0001;
    tick(4);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd0) begin
      failures++; $display("FAIL level_req: got req=%b id=%0d, required 1 0", int_req, int_id);
    end
    int_ack = 1'b1;
    tick(1);
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000) begin
      failures++; $display("FAIL level_clear: got req=%b pend=%b, required 0 0000", int_req, pending);
    end
    tick(1);
    checks++;
    if (pending !== 4'b0001 || int_req !== 1'b0) begin
      failures++; $display("FAIL level_repend: got pend=%b req=%b, required 0001 0", pending, int_req);
    end
    tick(3);
    checks++;
    if (pending !== 4'b0001 || int_req !== 1'b0) begin
      failures++; $display("FAIL level_single_clear: got pend=%b req=%b, required 0001 0", pending, int_req);
    end
    exp_q.push_back(0);
    int_ack = 1'b0;
    tick(1);
    checks++;
    if (int_req !== 1'b0) begin
      failures++; $display("FAIL level_wait_exit: got req=%b, required 0", int_req);
    end
    tick(1);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd0) begin
      failures++; $display("FAIL level_rereq: got req=%b id=%0d, required 1 0", int_req, int_id);
    end
    irq_in = '0;
    tick(3);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    tick(4);
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000) begin
      failures++; $display("FAIL level_release: got req=%b pend=%b, required 0 0000", int_req, pending);
    end
  endtask

  task automatic test_collision();
    exp_q.push_back(2);
    irq_in = 4'b0100;
    tick(4);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd2) begin
      failures++; $display("FAIL coll_req: got req=%b id=%0d, required 1 2", int_req, int_id);
    end
    irq_in = '0;
    tick(3);
    irq_in = 4'b0100;
    tick(2);
    int_ack = 1'b1;
    tick(1);
    checks++;
    if (pending !== 4'b0100 || int_req !== 1'b0) begin
      failures++; $display("FAIL coll_set_wins: got pend=%b req=%b, required 0100 0", pending, int_req);
    end
    exp_q.push_back(2);
    int_ack = 1'b0;
    tick(2);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd2) begin
      failures++; $display("FAIL coll_repeat: got req=%b id=%0d, required 1 2", int_req, int_id);
    end
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    tick(1);
    irq_in = '0;
    tick(3);
    exp_q.push_back(2);
    for (int k = 0; k < 3; k++) begin
      irq_in = 4'b0100;
      tick(3);
      irq_in = '0;
      tick(3);
    end
    checks++;
    if (int_req !== 1'b1 || pending !== 4'b0100) begin
      failures++; $display("FAIL merge_req: got req=%b pend=%b, required 1 0100", int_req, pending);
    end
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    tick(4);
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000) begin
      failures++; $display("FAIL merge_single: got req=%b pend=%b, required 0 0000", int_req, pending);
    end
  endtask

  task automatic test_reset_mid();
    mask_d = 4'b0011; mask_we = 1'b1;
    tick(1);
    mask_we = 1'b0;
    exp_q.push_back(1);
    irq_in = 4'b0010;
    tick(4);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd1) begin
      failures++; $display("FAIL rst_pre_req: got req=%b id=%0d, required 1 1", int_req, int_id);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000 || mask_q !== 4'b1111) begin
      failures++; $display("FAIL rst_in_req: got req=%b pend=%b mask=%b, required 0 0000 1111", int_req, pending, mask_q);
    end
    tick(1);
    exp_q.push_back(1);
    reset = 1'b0;
    tick(3);
    checks++;
    if (pending !== 4'b0010 || int_req !== 1'b0) begin
      failures++; $display("FAIL rst_e3: got pend=%b req=%b, required 0010 0", pending, int_req);
    end
    tick(1);
    checks++;
    if (int_req !== 1'b1 || int_id !== 2'd1) begin
      failures++; $display("FAIL rst_e4: got req=%b id=%0d, required 1 1", int_req, int_id);
    end
    int_ack = 1'b1;
    tick(1);
    reset = 1'b1;
    #2;
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000 || mask_q !== 4'b1111) begin
      failures++; $display("FAIL rst_in_wait: got req=%b pend=%b mask=%b, required 0 0000 1111", int_req, pending, mask_q);
    end
    irq_in = '0; int_ack = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(4);
    checks++;
    if (int_req !== 1'b0 || pending !== 4'b0000) begin
      failures++; $display("FAIL rst_quiet: got req=%b pend=%b, required 0 0000", int_req, pending);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_edge();
    test_simultaneous();
    test_mask();
    test_level();
    test_collision();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d outstanding requests, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
